// File: rtl/mrmwrw_mem.sv
// Multi-port memory with readernum read ports, writernum write ports and
// rwnum shared read/write ports. Writes are lane-masked with a fixed
// collision priority. Read latency (0, 1 or 2) and read-under-write
// behaviour are set by parameters.
module mrmwrw_mem #(
    parameter int depth       = 32,
    parameter int addrbits    = 5,
    parameter int width       = 32,
    parameter int maskgran    = 8,
    parameter int readernum   = 2,
    parameter int writernum   = 2,
    parameter int rwnum       = 1,
    parameter int readlatency = 1,
    parameter int ruw         = 0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [readernum-1:0]                  read_ens,
    input  logic [addrbits*readernum-1:0]         read_addrs,
    output logic [width*readernum-1:0]            read_datas,
    output logic [readernum-1:0]                  read_valids,
    input  logic [writernum-1:0]                  write_ens,
    input  logic [(width/maskgran)*writernum-1:0] write_masks,
    input  logic [addrbits*writernum-1:0]         write_addrs,
    input  logic [width*writernum-1:0]            write_datas,
    input  logic [rwnum-1:0]                      rw_ens,
    input  logic [rwnum-1:0]                      rw_wmodes,
    input  logic [addrbits*rwnum-1:0]             rw_addrs,
    input  logic [width*rwnum-1:0]                rw_wdatas,
    input  logic [(width/maskgran)*rwnum-1:0]     rw_wmasks,
    output logic [width*rwnum-1:0]                rw_rdatas,
    output logic [rwnum-1:0]                      rw_rvalids
);

    localparam int nl = width / maskgran;      // mask lanes per word
    localparam int nw = writernum + rwnum;     // write slots
    localparam int nr = readernum + rwnum;     // read slots
    localparam logic [addrbits:0] depth_lim = (addrbits+1)'(depth);

    // Write slots are ordered by ascending priority: write ports first,
    // then rw ports, lower index before higher index.
    logic [nw-1:0]       wr_en;
    logic [addrbits-1:0] wr_addr [nw];
    logic [width-1:0]    wr_data [nw];
    logic [nl-1:0]       wr_mask [nw];

    // Read slots: read ports first, then rw ports.
    logic [nr-1:0]       rd_en;
    logic [addrbits-1:0] rd_addr [nr];
    logic [width-1:0]    rd_word [nr];

    logic [width-1:0]    out_data [nr];
    logic [nr-1:0]       out_valid;

    // NOTE: storage is deliberately left without reset so it maps onto RAM;
    // only the control and output registers are cleared.
    logic [width-1:0]    mem [depth];

    function automatic logic in_range(input logic [addrbits-1:0] a);
        return {1'b0, a} < depth_lim;
    endfunction

    // Flatten port buses into per-slot views; writes are squashed in reset
    always_comb begin
        for (int w = 0; w < writernum; w++) begin
            wr_en[w]   = write_ens[w] & reset;
            wr_addr[w] = write_addrs[w*addrbits +: addrbits];
            wr_data[w] = write_datas[w*width +: width];
            wr_mask[w] = write_masks[w*nl +: nl];
        end
        for (int r = 0; r < rwnum; r++) begin
            wr_en[writernum+r]   = rw_ens[r] & rw_wmodes[r] & reset;
            wr_addr[writernum+r] = rw_addrs[r*addrbits +: addrbits];
            wr_data[writernum+r] = rw_wdatas[r*width +: width];
            wr_mask[writernum+r] = rw_wmasks[r*nl +: nl];
        end
        for (int n = 0; n < readernum; n++) begin
            rd_en[n]   = read_ens[n];
            rd_addr[n] = read_addrs[n*addrbits +: addrbits];
        end
        for (int r = 0; r < rwnum; r++) begin
            rd_en[readernum+r]   = rw_ens[r] & ~rw_wmodes[r];
            rd_addr[readernum+r] = rw_addrs[r*addrbits +: addrbits];
        end
    end

    // Word each read slot would return, optionally merged with this edge's writes
    always_comb begin
        for (int s = 0; s < nr; s++) begin
            // NOTE: default assigned first so no path leaves rd_word unassigned
            // (which would infer a latch).
            rd_word[s] = '0;
            if (in_range(rd_addr[s])) begin
                rd_word[s] = mem[rd_addr[s]];
                if (ruw != 0 && readlatency != 0) begin
                    // Later slots overwrite earlier ones, giving the write priority
                    for (int w = 0; w < nw; w++) begin
                        for (int k = 0; k < nl; k++) begin
                            if (wr_en[w] && wr_mask[w][k] && wr_addr[w] == rd_addr[s]) begin
                                rd_word[s][k*maskgran +: maskgran] = wr_data[w][k*maskgran +: maskgran];
                            end
                        end
                    end
                end
            end
        end
    end

    // Lane-masked storage update; the last matching slot in priority order wins
    always_ff @(posedge clock) begin
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < nl; k++) begin
                if (wr_en[w] && wr_mask[w][k] && in_range(wr_addr[w])) begin
                    // NOTE: non-blocking so every slot sees pre-edge storage and
                    // the final assignment in loop order sets the lane.
                    mem[wr_addr[w]][k*maskgran +: maskgran] <= wr_data[w][k*maskgran +: maskgran];
                end
            end
        end
    end

    if (readlatency == 0) begin : g_lat0
        logic [width-1:0] hold_q [nr];

        // Remember the last delivered word so data holds between reads
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < nr; s++) hold_q[s] <= '0;
            end else begin
                for (int s = 0; s < nr; s++) begin
                    if (rd_en[s]) hold_q[s] <= rd_word[s];
                end
            end
        end

        // Same-cycle data straight from storage while enabled
        always_comb begin
            for (int s = 0; s < nr; s++) begin
                out_valid[s] = rd_en[s] & reset;
                out_data[s]  = out_valid[s] ? rd_word[s] : hold_q[s];
            end
        end
    end else if (readlatency == 1) begin : g_lat1
        logic [width-1:0] data_q [nr];
        logic [nr-1:0]    valid_q;

        // Single output register; data only reloads on an accepted read
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                valid_q <= '0;
                for (int s = 0; s < nr; s++) data_q[s] <= '0;
            end else begin
                valid_q <= rd_en;
                for (int s = 0; s < nr; s++) begin
                    if (rd_en[s]) data_q[s] <= rd_word[s];
                end
            end
        end

        // Present the output register on the ports
        always_comb begin
            for (int s = 0; s < nr; s++) begin
                out_valid[s] = valid_q[s];
                out_data[s]  = data_q[s];
            end
        end
    end else begin : g_lat2
        logic [width-1:0] data_s1 [nr];
        logic [nr-1:0]    valid_s1;
        logic [width-1:0] data_q [nr];
        logic [nr-1:0]    valid_q;

        // Two register stages; reset empties both so in-flight reads vanish
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                valid_s1 <= '0;
                valid_q  <= '0;
                for (int s = 0; s < nr; s++) begin
                    data_s1[s] <= '0;
                    data_q[s]  <= '0;
                end
            end else begin
                valid_s1 <= rd_en;
                valid_q  <= valid_s1;
                for (int s = 0; s < nr; s++) begin
                    if (rd_en[s])    data_s1[s] <= rd_word[s];
                    if (valid_s1[s]) data_q[s]  <= data_s1[s];
                end
            end
        end

        // Present the second stage on the ports
        always_comb begin
            for (int s = 0; s < nr; s++) begin
                out_valid[s] = valid_q[s];
                out_data[s]  = data_q[s];
            end
        end
    end

    // Route read slots back onto the flat output buses
    always_comb begin
        for (int n = 0; n < readernum; n++) begin
            read_datas[n*width +: width] = out_data[n];
            read_valids[n]               = out_valid[n];
        end
        for (int r = 0; r < rwnum; r++) begin
            rw_rdatas[r*width +: width] = out_data[readernum+r];
            rw_rvalids[r]               = out_valid[readernum+r];
        end
    end

endmodule

// File: tb/tb_mrmwrw_mem.sv
// Testbench for mrmwrw_mem: five instances (default, ruw=1, readlatency=2,
// readlatency=0, depth=24) share one stimulus set. A vector table covers
// the single-cycle behaviour; hand sequences cover pipelining, reset and
// out-of-range addresses.
module tb_mrmwrw_mem;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  read_ens;
    logic [9:0]  read_addrs;
    logic [1:0]  write_ens;
    logic [7:0]  write_masks;
    logic [9:0]  write_addrs;
    logic [63:0] write_datas;
    logic [0:0]  rw_ens;
    logic [0:0]  rw_wmodes;
    logic [4:0]  rw_addrs;
    logic [31:0] rw_wdatas;
    logic [3:0]  rw_wmasks;

    logic [63:0] dflt_rd, ruw1_rd, lat2_rd, lat0_rd, d24_rd;
    logic [1:0]  dflt_rv, ruw1_rv, lat2_rv, lat0_rv, d24_rv;
    logic [31:0] dflt_rwd, ruw1_rwd, lat2_rwd, lat0_rwd, d24_rwd;
    logic [0:0]  dflt_rwv, ruw1_rwv, lat2_rwv, lat0_rwv, d24_rwv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mrmwrw_mem u_dflt (
        .clock(clock), .reset(reset),
        .read_ens(read_ens), .read_addrs(read_addrs),
        .read_datas(dflt_rd), .read_valids(dflt_rv),
        .write_ens(write_ens), .write_masks(write_masks),
        .write_addrs(write_addrs), .write_datas(write_datas),
        .rw_ens(rw_ens), .rw_wmodes(rw_wmodes), .rw_addrs(rw_addrs),
        .rw_wdatas(rw_wdatas), .rw_wmasks(rw_wmasks),
        .rw_rdatas(dflt_rwd), .rw_rvalids(dflt_rwv)
    );

    mrmwrw_mem #(.ruw(1)) u_ruw1 (
        .clock(clock), .reset(reset),
        .read_ens(read_ens), .read_addrs(read_addrs),
        .read_datas(ruw1_rd), .read_valids(ruw1_rv),
        .write_ens(write_ens), .write_masks(write_masks),
        .write_addrs(write_addrs), .write_datas(write_datas),
        .rw_ens(rw_ens), .rw_wmodes(rw_wmodes), .rw_addrs(rw_addrs),
        .rw_wdatas(rw_wdatas), .rw_wmasks(rw_wmasks),
        .rw_rdatas(ruw1_rwd), .rw_rvalids(ruw1_rwv)
    );

    mrmwrw_mem #(.readlatency(2)) u_lat2 (
        .clock(clock), .reset(reset),
        .read_ens(read_ens), .read_addrs(read_addrs),
        .read_datas(lat2_rd), .read_valids(lat2_rv),
        .write_ens(write_ens), .write_masks(write_masks),
        .write_addrs(write_addrs), .write_datas(write_datas),
        .rw_ens(rw_ens), .rw_wmodes(rw_wmodes), .rw_addrs(rw_addrs),
        .rw_wdatas(rw_wdatas), .rw_wmasks(rw_wmasks),
        .rw_rdatas(lat2_rwd), .rw_rvalids(lat2_rwv)
    );

    mrmwrw_mem #(.readlatency(0)) u_lat0 (
        .clock(clock), .reset(reset),
        .read_ens(read_ens), .read_addrs(read_addrs),
        .read_datas(lat0_rd), .read_valids(lat0_rv),
        .write_ens(write_ens), .write_masks(write_masks),
        .write_addrs(write_addrs), .write_datas(write_datas),
        .rw_ens(rw_ens), .rw_wmodes(rw_wmodes), .rw_addrs(rw_addrs),
        .rw_wdatas(rw_wdatas), .rw_wmasks(rw_wmasks),
        .rw_rdatas(lat0_rwd), .rw_rvalids(lat0_rwv)
    );

    mrmwrw_mem #(.depth(24)) u_d24 (
        .clock(clock), .reset(reset),
        .read_ens(read_ens), .read_addrs(read_addrs),
        .read_datas(d24_rd), .read_valids(d24_rv),
        .write_ens(write_ens), .write_masks(write_masks),
        .write_addrs(write_addrs), .write_datas(write_datas),
        .rw_ens(rw_ens), .rw_wmodes(rw_wmodes), .rw_addrs(rw_addrs),
        .rw_wdatas(rw_wdatas), .rw_wmasks(rw_wmasks),
        .rw_rdatas(d24_rwd), .rw_rvalids(d24_rwv)
    );

    // One cycle of stimulus plus the outputs expected just after its edge
    // (default instance; ed0n is port 0 data expected from the ruw=1 instance).
    typedef struct packed {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wm0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  wm1;
        logic        rwen;
        logic        rwmode;
        logic [4:0]  rwa;
        logic [31:0] rwd;
        logic [3:0]  rwm;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  ev;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        erwv;
        logic [31:0] erwd;
        logic [31:0] ed0n;
    } vec_t;

    localparam int n_rows = 11;
    vec_t tbl [n_rows];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        read_ens    = '0;
        read_addrs  = '0;
        write_ens   = '0;
        write_masks = '0;
        write_addrs = '0;
        write_datas = '0;
        rw_ens      = '0;
        rw_wmodes   = '0;
        rw_addrs    = '0;
        rw_wdatas   = '0;
        rw_wmasks   = '0;
    endtask

    task automatic apply(input vec_t v);
        write_ens   = v.we;
        write_addrs = {v.wa1, v.wa0};
        write_datas = {v.wd1, v.wd0};
        write_masks = {v.wm1, v.wm0};
        rw_ens      = v.rwen;
        rw_wmodes   = v.rwmode;
        rw_addrs    = v.rwa;
        rw_wdatas   = v.rwd;
        rw_wmasks   = v.rwm;
        read_ens    = v.re;
        read_addrs  = {v.ra1, v.ra0};
    endtask

    // Fresh row: no stimulus, no valids, output data expected to hold
    function automatic vec_t next_row(input vec_t p);
        vec_t n;
        n      = '0;
        n.ed0  = p.ed0;
        n.ed1  = p.ed1;
        n.erwd = p.erwd;
        n.ed0n = p.ed0n;
        return n;
    endfunction

    initial begin
        vec_t v;
        logic [31:0] lat2_exp [4];

        // ---- vector table ----
        v = '0;
        tbl[0] = v;
        v = next_row(v); v.we = 2'b01; v.wa0 = 5'd3; v.wd0 = 32'hDEADBEEF; v.wm0 = 4'hF;
        tbl[1] = v;
        v = next_row(v); v.re = 2'b10; v.ra1 = 5'd3; v.ev = 2'b10; v.ed1 = 32'hDEADBEEF;
        tbl[2] = v;
        v = next_row(v); v.we = 2'b11;
        v.wa0 = 5'd5; v.wd0 = 32'h11111111; v.wm0 = 4'hF;
        v.wa1 = 5'd5; v.wd1 = 32'h22222222; v.wm1 = 4'hF;
        v.rwen = 1'b1; v.rwmode = 1'b1; v.rwa = 5'd5; v.rwd = 32'h33333333; v.rwm = 4'h1;
        tbl[3] = v;
        v = next_row(v); v.re = 2'b01; v.ra0 = 5'd5; v.rwen = 1'b1; v.rwmode = 1'b0; v.rwa = 5'd3;
        v.ev = 2'b01; v.ed0 = 32'h22222233; v.ed0n = 32'h22222233; v.erwv = 1'b1; v.erwd = 32'hDEADBEEF;
        tbl[4] = v;
        v = next_row(v); v.we = 2'b01; v.wa0 = 5'd7; v.wd0 = 32'hA5A5A5A5; v.wm0 = 4'hF;
        tbl[5] = v;
        v = next_row(v); v.re = 2'b01; v.ra0 = 5'd7;
        v.we = 2'b10; v.wa1 = 5'd7; v.wd1 = 32'h5A5A5A5A; v.wm1 = 4'hF;
        v.ev = 2'b01; v.ed0 = 32'hA5A5A5A5; v.ed0n = 32'h5A5A5A5A;
        tbl[6] = v;
        v = next_row(v); v.re = 2'b01; v.ra0 = 5'd7;
        v.we = 2'b01; v.wa0 = 5'd3; v.wd0 = 32'h0; v.wm0 = 4'h2;
        v.ev = 2'b01; v.ed0 = 32'h5A5A5A5A; v.ed0n = 32'h5A5A5A5A;
        tbl[7] = v;
        v = next_row(v); v.re = 2'b10; v.ra1 = 5'd3; v.ev = 2'b10; v.ed1 = 32'hDEAD00EF;
        tbl[8] = v;
        v = next_row(v); v.re = 2'b11; v.ra0 = 5'd5; v.ra1 = 5'd7;
        v.rwen = 1'b1; v.rwmode = 1'b0; v.rwa = 5'd7;
        v.ev = 2'b11; v.ed0 = 32'h22222233; v.ed0n = 32'h22222233; v.ed1 = 32'h5A5A5A5A;
        v.erwv = 1'b1; v.erwd = 32'h5A5A5A5A;
        tbl[9] = v;
        v = next_row(v);
        tbl[10] = v;

        // ---- reset state ----
        clr();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset dflt valids", 64'(dflt_rv), 64'd0);
        check("reset dflt datas", dflt_rd, 64'd0);
        check("reset dflt rw valid", 64'(dflt_rwv), 64'd0);
        check("reset lat2 valids", 64'(lat2_rv), 64'd0);
        reset = 1'b1;

        // ---- table-driven single-cycle behaviour ----
        for (int i = 0; i < n_rows; i++) begin
            apply(tbl[i]);
            @(posedge clock);
            #1;
            check($sformatf("row%0d valids", i), 64'(dflt_rv), 64'(tbl[i].ev));
            check($sformatf("row%0d data0", i), 64'(dflt_rd[31:0]), 64'(tbl[i].ed0));
            check($sformatf("row%0d data1", i), 64'(dflt_rd[63:32]), 64'(tbl[i].ed1));
            check($sformatf("row%0d rw valid", i), 64'(dflt_rwv), 64'(tbl[i].erwv));
            check($sformatf("row%0d rw data", i), 64'(dflt_rwd), 64'(tbl[i].erwd));
            check($sformatf("row%0d ruw1 valids", i), 64'(ruw1_rv), 64'(tbl[i].ev));
            check($sformatf("row%0d ruw1 data0", i), 64'(ruw1_rd[31:0]), 64'(tbl[i].ed0n));
            check($sformatf("row%0d ruw1 data1", i), 64'(ruw1_rd[63:32]), 64'(tbl[i].ed1));
        end

        // ---- readlatency 0: same-cycle data, then hold ----
        clr();
        read_ens = 2'b01;
        read_addrs[4:0] = 5'd5;
        #1;
        check("lat0 valid same cycle", 64'(lat0_rv), 64'd1);
        check("lat0 data same cycle", 64'(lat0_rd[31:0]), 64'h22222233);
        @(posedge clock);
        #1;
        clr();
        #1;
        check("lat0 valid idle", 64'(lat0_rv), 64'd0);
        check("lat0 data held", 64'(lat0_rd[31:0]), 64'h22222233);

        // ---- readlatency 2: back-to-back reads ----
        clr();
        write_ens = 2'b11;
        write_masks = 8'hFF;
        write_addrs = {5'd1, 5'd0};
        write_datas = {32'h20202020, 32'h10101010};
        rw_ens = 1'b1; rw_wmodes = 1'b1; rw_addrs = 5'd2;
        rw_wdatas = 32'h30303030; rw_wmasks = 4'hF;
        @(posedge clock);
        #1;
        lat2_exp[0] = 32'h10101010;
        lat2_exp[1] = 32'h20202020;
        lat2_exp[2] = 32'h30303030;
        lat2_exp[3] = 32'hDEAD00EF;
        for (int c = 0; c < 6; c++) begin
            clr();
            if (c < 4) begin
                read_ens = 2'b01;
                read_addrs[4:0] = 5'(c);
            end
            @(posedge clock);
            #1;
            check($sformatf("lat2 cycle%0d valids", c), 64'(lat2_rv),
                  (c >= 1 && c <= 4) ? 64'd1 : 64'd0);
            if (c >= 1 && c <= 4)
                check($sformatf("lat2 cycle%0d data", c), 64'(lat2_rd[31:0]), 64'(lat2_exp[c-1]));
        end

        // ---- depth 24: out-of-range addresses ----
        clr();
        write_ens = 2'b11;
        write_masks = 8'hFF;
        write_addrs = {5'd14, 5'd6};
        write_datas = {32'h14141414, 32'h06060606};
        @(posedge clock);
        #1;
        clr();
        write_ens = 2'b01;
        write_masks = 8'h0F;
        write_addrs[4:0] = 5'd30;
        write_datas[31:0] = 32'h77777777;
        read_ens = 2'b01;
        read_addrs[4:0] = 5'd30;
        @(posedge clock);
        #1;
        check("d24 oor valid", 64'(d24_rv), 64'd1);
        check("d24 oor data", 64'(d24_rd[31:0]), 64'd0);
        clr();
        read_ens = 2'b11;
        read_addrs = {5'd14, 5'd6};
        @(posedge clock);
        #1;
        check("d24 addr6 untouched", 64'(d24_rd[31:0]), 64'h06060606);
        check("d24 addr14 untouched", 64'(d24_rd[63:32]), 64'h14141414);
        clr();
        read_ens = 2'b01;
        read_addrs[4:0] = 5'd30;
        @(posedge clock);
        #1;
        check("d24 oor after write", 64'(d24_rd[31:0]), 64'd0);
        check("dflt addr30 written", 64'(dflt_rd[31:0]), 64'h77777777);

        // ---- reset in the middle of a read ----
        clr();
        read_ens = 2'b01;
        read_addrs[4:0] = 5'd5;
        @(posedge clock);
        #1;
        check("prereset dflt data", 64'(dflt_rd[31:0]), 64'h22222233);
        reset = 1'b0;
        clr();
        write_ens = 2'b01;
        write_masks = 8'h0F;
        write_addrs[4:0] = 5'd5;
        write_datas[31:0] = 32'hFFFFFFFF;
        #1;
        check("in reset dflt valids", 64'(dflt_rv), 64'd0);
        check("in reset dflt datas", dflt_rd, 64'd0);
        check("in reset lat2 valids", 64'(lat2_rv), 64'd0);
        check("in reset lat2 datas", lat2_rd, 64'd0);
        @(posedge clock);
        #1;
        check("in reset lat2 valids later", 64'(lat2_rv), 64'd0);
        reset = 1'b1;
        clr();
        read_ens = 2'b01;
        read_addrs[4:0] = 5'd5;
        @(posedge clock);
        #1;
        check("post reset dflt valid", 64'(dflt_rv), 64'd1);
        check("post reset word kept", 64'(dflt_rd[31:0]), 64'h22222233);
        check("post reset lat2 discarded", 64'(lat2_rv), 64'd0);
        clr();
        @(posedge clock);
        #1;
        check("post reset lat2 valid", 64'(lat2_rv), 64'd1);
        check("post reset lat2 data", 64'(lat2_rd[31:0]), 64'h22222233);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
